// File: rtl/control_word_pipe.sv
// control_word_pipe: DEPTH-stage control word pipeline with valid, stall, flush, stall watchdog; CW_PARITY_EN adds per-stage parity check
module control_word_pipe #(
  parameter int CW_W = 44,
  parameter int DEPTH = 1,
  parameter logic [CW_W-1:0] NOP_WORD = '0,
  parameter int N_W = 3,
  parameter int unsigned STALL_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CW_W-1:0] cw_in,
  input  logic            cw_valid_in,
  input  logic            cw_par,
  input  logic            stall,
  input  logic            flush,
  output logic [CW_W-1:0] cw_out,
  output logic            cw_valid_out,
  output logic [N_W-1:0]  n_sel,
  output logic [3:0]      stall_cnt,
  output logic            stall_timeout,
  output logic            parity_err
);
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("control_word_pipe: DEPTH must be 1..4");
  end
  if (CW_W <= N_W) begin : g_bad_width
    $error("control_word_pipe: CW_W must exceed N_W");
  end
  logic [CW_W-1:0] word [DEPTH];
  logic [DEPTH-1:0] vld;
`ifdef CW_PARITY_EN
  logic [DEPTH-1:0] par;
`endif
  // reset and flush both empty the pipe; stall freezes it and counts; otherwise shift one stage
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) word[i] <= NOP_WORD;
      vld <= '0;
`ifdef CW_PARITY_EN
      par <= '0;
`endif
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= (stall_cnt == 4'd15) ? 4'd15 : stall_cnt + 4'd1;
    end else begin
      word[0] <= cw_valid_in ? cw_in : NOP_WORD;
      vld[0] <= cw_valid_in;
`ifdef CW_PARITY_EN
      par[0] <= cw_par;
`endif
      for (int i = 1; i < DEPTH; i++) begin
        word[i] <= word[i-1];
        vld[i] <= vld[i-1];
`ifdef CW_PARITY_EN
        par[i] <= par[i-1];
`endif
      end
      stall_cnt <= '0;
    end
  end
  assign cw_valid_out = vld[DEPTH-1];
  assign cw_out = vld[DEPTH-1] ? word[DEPTH-1] : NOP_WORD;
  assign n_sel = cw_out[N_W-1:0];
  assign stall_timeout = 32'(stall_cnt) >= STALL_MAX;
`ifdef CW_PARITY_EN
  assign parity_err = vld[DEPTH-1] & ((^word[DEPTH-1]) ^ par[DEPTH-1]);
`else
  logic unused_par;
  assign unused_par = cw_par;
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_control_word_pipe.sv
// tb_control_word_pipe: four pipe configurations driven in parallel and checked against a queue-based reference
module tb_control_word_pipe;
  localparam logic [43:0] NOP4 = 44'h5A5_0000_0F1;
  logic clk = 1'b0;
  logic reset, cw_valid_in, cw_par, stall, flush;
  logic [43:0] cw_in;
  logic [43:0] o_cw [4];
  logic [2:0] o_n [4];
  logic [3:0] o_sc [4];
  logic o_v [4];
  logic o_to [4];
  logic o_pe [4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : gi
    control_word_pipe #(
      .DEPTH(g + 1),
      .NOP_WORD(g == 3 ? NOP4 : 44'h0),
      .STALL_MAX(g == 3 ? 5 : 15)
    ) u (
      .clk(clk), .reset(reset), .cw_in(cw_in), .cw_valid_in(cw_valid_in),
      .cw_par(cw_par), .stall(stall), .flush(flush), .cw_out(o_cw[g]),
      .cw_valid_out(o_v[g]), .n_sel(o_n[g]), .stall_cnt(o_sc[g]),
      .stall_timeout(o_to[g]), .parity_err(o_pe[g])
    );
  end
  typedef struct packed {logic p; logic v; logic [43:0] w;} ent_t;
  ent_t q [4][$];
  int cnt = 0;
  int n_chk = 0;
  int n_fail = 0;
  function automatic logic [43:0] nop_of(int k);
    return k == 3 ? NOP4 : 44'h0;
  endfunction
  function automatic int smax(int k);
    return k == 3 ? 5 : 15;
  endfunction
  task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[D%0d] observed=%h expected=%h", tag, k + 1, obs, exp);
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      ent_t t = q[k][$];
      logic [43:0] e = t.v ? t.w : nop_of(k);
      chk("cw_out", k, 64'(o_cw[k]), 64'(e));
      chk("cw_valid_out", k, 64'(o_v[k]), 64'(t.v));
      chk("n_sel", k, 64'(o_n[k]), 64'(e[2:0]));
      chk("stall_cnt", k, 64'(o_sc[k]), 64'(cnt));
      chk("stall_timeout", k, 64'(o_to[k]), 64'(cnt >= smax(k)));
`ifdef CW_PARITY_EN
      chk("parity_err", k, 64'(o_pe[k]), 64'(t.v & ((^t.w) ^ t.p)));
`else
      chk("parity_err", k, 64'(o_pe[k]), 64'(0));
`endif
    end
  endtask
  task automatic cyc(logic r, logic [43:0] w, logic v, logic p, logic st, logic fl);
    reset = r; cw_in = w; cw_valid_in = v; cw_par = p; stall = st; flush = fl;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (r || fl) begin
        q[k].delete();
        for (int i = 0; i <= k; i++) q[k].push_back({1'b0, 1'b0, nop_of(k)});
      end else if (!st) begin
        q[k].push_front({p, v, v ? w : nop_of(k)});
        void'(q[k].pop_back());
      end
    end
    cnt = (r || fl) ? 0 : st ? (cnt < 15 ? cnt + 1 : 15) : 0;
    #1 check_all();
  endtask
  initial begin
    for (int k = 0; k < 4; k++)
      for (int i = 0; i <= k; i++) q[k].push_back({1'b0, 1'b0, nop_of(k)});
    cyc(1, 44'h0, 0, 0, 0, 0);
    cyc(1, 44'h0, 0, 0, 0, 0);
    cyc(0, 44'h0100_0000_023, 1, 1'b0, 0, 0);
    chk("s1_cw_out", 0, 64'(o_cw[0]), 64'h0100_0000_023);
    chk("s1_n_sel", 0, 64'(o_n[0]), 64'(3'b011));
    cyc(0, 44'h1, 1, 1, 0, 0);
    cyc(0, 44'h2, 1, 1, 0, 0);
    cyc(0, 44'h3, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 44'hABC, 0, 0, 0, 0);
    cyc(0, 44'hA, 1, 0, 0, 0);
    cyc(0, 44'hB, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 44'hEEE, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 44'h0, 0, 0, 0, 0);
    cyc(0, 44'hA, 1, 0, 0, 0);
    cyc(0, 44'hB, 1, 1, 0, 0);
    cyc(0, 44'hC, 1, 1, 1, 1);
    cyc(0, 44'hD, 1, 1, 0, 0);
    cyc(0, 44'h0, 0, 0, 0, 0);
    cyc(0, 44'h0, 0, 0, 0, 0);
    cyc(0, 44'h55, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 44'h66, 1, 0, 1, 0);
    cyc(0, 44'h77, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 44'h88, 1, 0, 1, 0);
    cyc(1, 44'h99, 1, 0, 1, 0);
    cyc(0, 44'h7, 1, 0, 0, 0);
    cyc(0, 44'h7, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 44'h0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [43:0] w = {$urandom, $urandom};
      cyc($urandom_range(0, 49) == 0, w, $urandom_range(0, 9) < 7,
          (^w) ^ ($urandom_range(0, 7) == 0),
          $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
